lab2_proc_mem_funnel: RTL
=========================

# lab2_proc_mem_funnel

Merges the processor's instruction-memory and data-memory request streams into one shared memory port and routes responses back to the correct stream. It sits directly downstream of the processor's imem/dmem request and response ports, between the core and a single-ported test memory or cache. It uses round-robin arbitration and a per-source outstanding-request limit. Each request is tagged with its source in the opaque field, and the tag is stripped from the response.

## Interface
Parameters:
- p_max_outstanding, 4: maximum in-flight requests per source (1..15)

Ports (all messages use the codebase's mem_req_4B_t / mem_resp_4B_t):
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- imem_reqstream_msg/val/rdy  input/input/output  mem_req_4B_t/1/1  instruction request stream from the core
- imem_respstream_msg/val/rdy  output/output/input  mem_resp_4B_t/1/1  instruction response stream to the core
- dmem_reqstream_msg/val/rdy  input/input/output  mem_req_4B_t/1/1  data request stream from the core
- dmem_respstream_msg/val/rdy  output/output/input  mem_resp_4B_t/1/1  data response stream to the core
- mem_reqstream_msg/val/rdy  output/output/input  mem_req_4B_t/1/1  merged request stream to memory
- mem_respstream_msg/val/rdy  input/input/output  mem_resp_4B_t/1/1  merged response stream from memory

## Operation
- **Handshakes.** All streams use val/rdy. A transfer occurs on a cycle where val && rdy.
  - Producers hold msg and val stable until the transfer.
  - No rdy output depends combinationally on val of the same stream.
- **Request tagging.** The forwarded request is identical to the source request except opaque[7]: 0 = imem, 1 = dmem.
  - Sources must drive opaque[7] = 0; a simulation assertion fires if not.
- **Arbitration.** A 1-bit priority register `prio` (0 = imem preferred) decides which source is granted.
  - A source is eligible if its val is high and its counter cnt_s < p_max_outstanding.
  - Grant goes to the preferred eligible source, else to the other eligible source.
  - Only the granted source sees rdy, and only when the output buffer can accept an entry.
  - After any request transfer, prio points to the source not just granted.
- **Output buffer.** A 2-entry normal (non-bypass) queue between the arbiter and mem_reqstream.
- **Outstanding counters.** cnt_imem and cnt_dmem are each $clog2(p_max_outstanding+1) bits wide.
  - +1 on that source's request transfer.
  - −1 on a response transfer whose opaque[7] selects that source.
  - A simultaneous +1 and −1 leaves the counter unchanged.
  - A decrement at 0 saturates at 0 and fires a simulation assertion.
- **Response routing.** The response is steered to imem_resp when opaque[7] = 0 and to dmem_resp when opaque[7] = 1.
  - The forwarded response has opaque[7] cleared; all other fields pass unchanged.
  - Only the selected response port sees val.
  - mem_respstream_rdy equals the selected port's rdy.
- Responses may return in any order across sources. Per-source ordering is whatever memory provides; the funnel does not reorder.

## Timing
- Reset values:
  - prio = 0; both counters = 0; output queue empty.
  - mem_reqstream_val = 0, imem/dmem_respstream_val = 0.
  - imem_reqstream_rdy = dmem_reqstream_rdy = 0 during reset.
- Request latency: a grant at posedge N gives mem_reqstream_val = 1 in cycle N+1 (one register stage).
- Throughput: one request per cycle when mem_reqstream_rdy is held high.
- Response path: combinational, 0 cycles.
- Backpressure:
  - With the queue full and mem_reqstream_rdy = 0, both source rdy are 0.
  - When mem_reqstream_rdy rises, a new grant is accepted in the same cycle a queue entry drains (count-based full check, no bubble).
- Outstanding limit: once cnt_s = p_max_outstanding, that source's rdy is 0.
  - Its rdy may rise in the same cycle as a response to that source is accepted.
  - The other source keeps flowing meanwhile.
- Reset mid-operation: all state clears at that posedge; any queued requests are discarded.
  - Late responses to pre-reset requests are still routed by opaque[7], and the counter saturates at 0.
  - The system must reset memory concurrently.

## Structure
- Shared package (lab2_proc_mem_funnel_pkg or the existing tinyrv2 encoding header):
  - localparams SRC_IMEM = 1'b0, SRC_DMEM = 1'b1.
  - Tag bit position constant MEM_FUNNEL_TAG_BIT = 7.
- One natural sub-module: lab2_proc_rr_arb2.
  - 2-input round-robin arbiter holding `prio`, with inputs req[1:0] and en, output grant[1:0].
- The output buffer reuses the existing vc_Queue in normal mode with 2 entries.
- Counters and response steering are inline.

## Test plan
- Reset, then imem alone sends reads to 0x200, 0x204, 0x208 with mem_reqstream_rdy = 1.
  - Expect mem requests in consecutive cycles starting one cycle after each grant, all with opaque = 0x00.
  - Responses with opaque = 0x00 appear on imem_resp only.
- imem and dmem both valid every cycle (imem 0x200…, dmem write 0x1000 data 0xdeadbeef).
  - Expect grants to alternate imem, dmem, imem… starting with imem after reset.
  - dmem requests carry opaque = 0x80.
- Memory never responds; imem issues continuously.
  - Expect exactly p_max_outstanding = 4 imem grants, then imem_reqstream_rdy = 0.
  - dmem is still accepted.
  - One imem response raises imem_rdy in that same cycle.
- Responses returned out of order (dmem opaque 0x80 before an older imem 0x00).
  - Each response lands on the correct port with opaque 0x00, and the counters return to 0.
- Random mem_reqstream_rdy / response-port rdy stalls over 500 mixed transactions, compared against a scoreboard.
  - No loss, duplication, or misroute; val/msg stable under backpressure.
- Assert reset with 2 requests queued and counters at 3/2.
  - Next cycle: queue empty, mem_reqstream_val = 0, counters 0, prio = 0 (imem granted first).

Source files
------------

// File: rtl/lab2_proc_mem_funnel_pkg.sv
// Shared types and constants for the imem/dmem request funnel.
package lab2_proc_mem_funnel_pkg;

  // Source identifiers carried in the tag bit of the opaque field
  localparam logic SRC_IMEM = 1'b0;
  localparam logic SRC_DMEM = 1'b1;

  // Opaque bit that carries the source tag on the shared memory port
  localparam int unsigned MEM_FUNNEL_TAG_BIT = 7;

  // Memory message type field encodings
  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Overwrite the tag bit of an opaque field with a source identifier
  function automatic logic [7:0] set_tag(input logic [7:0] opaque, input logic src);
    logic [7:0] result;
    result = opaque;
    result[MEM_FUNNEL_TAG_BIT] = src;
    return result;
  endfunction

endpackage

// File: rtl/lab2_proc_mem_funnel_queue.sv
// Two-entry normal (non-bypass) queue. Full-check is count based, so an
// enqueue is accepted in the same cycle the head entry drains.
module lab2_proc_mem_funnel_queue #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enq_val_i,
  output logic             enq_rdy_o,
  input  logic [Width-1:0] enq_msg_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [Width-1:0] deq_msg_o
);

  logic [Width-1:0] entry_q [2];
  logic             head_q;
  logic             head_d;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             enq_fire;
  logic             deq_fire;
  logic             tail;

  // Handshake, pointer and occupancy next-state
  always_comb begin
    deq_val_o = (count_q != 2'd0);
    enq_rdy_o = (count_q != 2'd2) | deq_rdy_i;
    deq_fire  = deq_val_o & deq_rdy_i;
    enq_fire  = enq_val_i & enq_rdy_o;
    // With two slots the tail sits one past head for count 1, on head otherwise
    tail      = head_q ^ count_q[0];
    deq_msg_o = entry_q[head_q];
    head_d    = deq_fire ? ~head_q : head_q;
    count_d   = count_q;
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy state; reset discards any queued entries
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity comes from count_q
  always_ff @(posedge clk_i) begin
    if (enq_fire) entry_q[tail] <= enq_msg_i;
  end

endmodule

// File: rtl/lab2_proc_rr_arb2.sv
// Two-input round-robin arbiter. prio names the preferred requester; after a
// granted transfer it moves to the requester that was not just served.
module lab2_proc_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o,
  output logic       prio_o
);

  logic prio_q;
  logic prio_d;

  // Grant the preferred requester if it asks, otherwise the other one
  always_comb begin
    grant_o = 2'b00;
    if (prio_q == 1'b0) begin
      if (req_i[0])      grant_o = 2'b01;
      else if (req_i[1]) grant_o = 2'b10;
    end else begin
      if (req_i[1])      grant_o = 2'b10;
      else if (req_i[0]) grant_o = 2'b01;
    end
  end

  // Rotate priority away from whoever was just served
  always_comb begin
    prio_d = prio_q;
    if (en_i && grant_o[0])      prio_d = 1'b1;
    else if (en_i && grant_o[1]) prio_d = 1'b0;
  end

  // Priority register, imem preferred out of reset
  always_ff @(posedge clk_i) begin
    if (reset_i) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/lab2_proc_mem_funnel.sv
// Funnels imem and dmem request streams onto one memory port with round-robin
// arbitration and per-source outstanding limits, and steers responses back
// by the source tag carried in opaque[7].
module lab2_proc_mem_funnel
  import lab2_proc_mem_funnel_pkg::*;
#(
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,

  input  mem_req_4B_t  imem_reqstream_msg_i,
  input  logic         imem_reqstream_val_i,
  output logic         imem_reqstream_rdy_o,

  output mem_resp_4B_t imem_respstream_msg_o,
  output logic         imem_respstream_val_o,
  input  logic         imem_respstream_rdy_i,

  input  mem_req_4B_t  dmem_reqstream_msg_i,
  input  logic         dmem_reqstream_val_i,
  output logic         dmem_reqstream_rdy_o,

  output mem_resp_4B_t dmem_respstream_msg_o,
  output logic         dmem_respstream_val_o,
  input  logic         dmem_respstream_rdy_i,

  output mem_req_4B_t  mem_reqstream_msg_o,
  output logic         mem_reqstream_val_o,
  input  logic         mem_reqstream_rdy_i,

  input  mem_resp_4B_t mem_respstream_msg_i,
  input  logic         mem_respstream_val_i,
  output logic         mem_respstream_rdy_o
);

  localparam int unsigned CntW = $clog2(p_max_outstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(p_max_outstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_imem_q, cnt_imem_d;
  logic [CntW-1:0] cnt_dmem_q, cnt_dmem_d;

  logic         resp_tag;
  logic         resp_fire;
  logic         dec_imem, dec_dmem;
  logic         ok_imem, ok_dmem;
  logic [1:0]   elig;
  logic [1:0]   grant;
  logic         prio;
  logic         space;
  logic         imem_fire, dmem_fire;
  mem_req_4B_t  enq_msg;
  logic         enq_val;
  logic         q_enq_rdy;
  logic         q_deq_val;
  logic [$bits(mem_req_4B_t)-1:0] q_deq_msg;
  mem_resp_4B_t resp_untagged;

  // Response steering by tag; the tag bit is cleared on the way back
  always_comb begin
    resp_tag                       = mem_respstream_msg_i.opaque[MEM_FUNNEL_TAG_BIT];
    resp_untagged                  = mem_respstream_msg_i;
    resp_untagged.opaque[MEM_FUNNEL_TAG_BIT] = 1'b0;
    imem_respstream_msg_o          = resp_untagged;
    dmem_respstream_msg_o          = resp_untagged;
    imem_respstream_val_o          = mem_respstream_val_i & (resp_tag == SRC_IMEM);
    dmem_respstream_val_o          = mem_respstream_val_i & (resp_tag == SRC_DMEM);
    mem_respstream_rdy_o           = (resp_tag == SRC_DMEM) ? dmem_respstream_rdy_i
                                                            : imem_respstream_rdy_i;
    resp_fire                      = mem_respstream_val_i & mem_respstream_rdy_o;
    dec_imem                       = resp_fire & (resp_tag == SRC_IMEM);
    dec_dmem                       = resp_fire & (resp_tag == SRC_DMEM);
  end

  // Eligibility and per-source ready; a returning response frees its slot at once
  always_comb begin
    ok_imem = (cnt_imem_q < CntMax) | dec_imem;
    ok_dmem = (cnt_dmem_q < CntMax) | dec_dmem;
    elig    = {dmem_reqstream_val_i & ok_dmem, imem_reqstream_val_i & ok_imem};
    space   = q_enq_rdy & ~reset_i;
    // A source's rdy only looks at the other source's val, never its own
    imem_reqstream_rdy_o = space & ok_imem & ~(prio & elig[1]);
    dmem_reqstream_rdy_o = space & ok_dmem & ~(~prio & elig[0]);
    imem_fire = imem_reqstream_val_i & imem_reqstream_rdy_o;
    dmem_fire = dmem_reqstream_val_i & dmem_reqstream_rdy_o;
    enq_val   = imem_fire | dmem_fire;
    enq_msg   = imem_reqstream_msg_i;
    enq_msg.opaque = set_tag(imem_reqstream_msg_i.opaque, SRC_IMEM);
    if (dmem_fire) begin
      enq_msg        = dmem_reqstream_msg_i;
      enq_msg.opaque = set_tag(dmem_reqstream_msg_i.opaque, SRC_DMEM);
    end
  end

  lab2_proc_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (elig),
    .en_i    (space),
    .grant_o (grant),
    .prio_o  (prio)
  );

  lab2_proc_mem_funnel_queue #(
    .Width ($bits(mem_req_4B_t))
  ) u_queue (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .enq_val_i (enq_val),
    .enq_rdy_o (q_enq_rdy),
    .enq_msg_i (enq_msg),
    .deq_val_o (q_deq_val),
    .deq_rdy_i (mem_reqstream_rdy_i),
    .deq_msg_o (q_deq_msg)
  );

  // Merged request port driven from the queue head
  always_comb begin
    mem_reqstream_val_o = q_deq_val & ~reset_i;
    mem_reqstream_msg_o = mem_req_4B_t'(q_deq_msg);
  end

  // Outstanding counters: simultaneous issue and return cancel, floor at zero
  always_comb begin
    cnt_imem_d = cnt_imem_q;
    if (imem_fire && !dec_imem)                          cnt_imem_d = cnt_imem_q + CntOne;
    else if (!imem_fire && dec_imem && cnt_imem_q != '0) cnt_imem_d = cnt_imem_q - CntOne;
    cnt_dmem_d = cnt_dmem_q;
    if (dmem_fire && !dec_dmem)                          cnt_dmem_d = cnt_dmem_q + CntOne;
    else if (!dmem_fire && dec_dmem && cnt_dmem_q != '0) cnt_dmem_d = cnt_dmem_q - CntOne;
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_imem_q <= '0;
      cnt_dmem_q <= '0;
    end else begin
      cnt_imem_q <= cnt_imem_d;
      cnt_dmem_q <= cnt_dmem_d;
    end
  end

  // Protocol checks: sources must leave the tag bit clear, no underflow
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (imem_reqstream_val_i) assert (imem_reqstream_msg_i.opaque[MEM_FUNNEL_TAG_BIT] == 1'b0);
      if (dmem_reqstream_val_i) assert (dmem_reqstream_msg_i.opaque[MEM_FUNNEL_TAG_BIT] == 1'b0);
      if (dec_imem) assert (cnt_imem_q != '0);
      if (dec_dmem) assert (cnt_dmem_q != '0);
    end
  end
`endif

endmodule
